hv_driver: RTL and testbench

//   Drive side of the HV line: turns a generator HV request into the registered `hv` output.

---
 rtl/hv_driver.sv | 109 ++++++++++
 tb/tb_hv_driver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hv_driver.sv
// hv_driver: turns a generator HV request into the registered hv line enable.
// Applies a prescaled turn-on pre-delay and a minimum off (discharge) hold,
// and latches a fault lockout that must be cleared explicitly.
module hv_driver #(
    parameter int PRESCALE_WIDTH = 16,
    parameter int WIDTH          = 16
) (
    input  logic                      clk,
    input  logic                      sclr,
    input  logic                      req,
    input  logic                      permit,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [WIDTH-1:0]          on_delay,
    input  logic [WIDTH-1:0]          off_time,
    input  logic                      fault,
    input  logic                      fault_clr,
    output logic                      hv,
    output logic                      on_pulse,
    output logic                      busy,
    output logic                      locked,
    output logic [2:0]                state
);

    localparam logic [2:0] ST_OFF      = 3'd0;
    localparam logic [2:0] ST_ON_DLY   = 3'd1;
    localparam logic [2:0] ST_ON       = 3'd2;
    localparam logic [2:0] ST_OFF_HOLD = 3'd3;
    localparam logic [2:0] ST_FAULT    = 3'd4;

    logic [2:0]                state_q;
    logic [2:0]                state_nx;
    logic [PRESCALE_WIDTH-1:0] timer;
    logic [WIDTH-1:0]          cnt;
    logic                      tick;
    logic                      done_on;
    logic                      done_off;
    logic                      state_chg;
    logic                      on_pulse_q;

    // Tick and delay-done decode; >= lets a lowered limit end the state on the next tick
    always_comb begin
        tick     = (timer >= prescale);
        done_on  = tick && (cnt >= on_delay);
        done_off = tick && (cnt >= off_time);
    end

    // Next-state logic; fault overrides every other transition
    always_comb begin
        state_nx = state_q;
        case (state_q)
            ST_OFF: begin
                if (req) state_nx = ST_ON_DLY;
            end
            ST_ON_DLY: begin
                if (!req)                  state_nx = ST_OFF;
                else if (permit || done_on) state_nx = ST_ON;
            end
            ST_ON: begin
                if (!req) state_nx = ST_OFF_HOLD;
            end
            ST_OFF_HOLD: begin
                if (permit || done_off) state_nx = ST_OFF;
            end
            ST_FAULT: begin
                if (!fault && fault_clr) state_nx = ST_OFF_HOLD;
            end
            default: state_nx = ST_OFF;
        endcase
        if (fault) state_nx = ST_FAULT;
        state_chg = (state_nx != state_q);
    end

    // State register and on-pulse strobe (set only on the cycle ON is entered)
    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q    <= ST_OFF;
            on_pulse_q <= 1'b0;
        end else begin
            state_q    <= state_nx;
            on_pulse_q <= (state_nx == ST_ON) && (state_q != ST_ON);
        end
    end

    // Prescale timer and tick counter; both restart on any state change, cnt saturates
    always_ff @(posedge clk) begin
        if (sclr) begin
            timer <= '0;
            cnt   <= '0;
        end else if (state_chg) begin
            timer <= '0;
            cnt   <= '0;
        end else if (tick) begin
            timer <= '0;
            if (cnt != '1) cnt <= cnt + 1'b1;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Output decode of the registered state
    always_comb begin
        state    = state_q;
        hv       = (state_q == ST_ON);
        on_pulse = on_pulse_q;
        busy     = (state_q == ST_ON_DLY) || (state_q == ST_OFF_HOLD);
        locked   = (state_q == ST_FAULT);
    end

endmodule

// File: tb/tb_hv_driver.sv
// tb_hv_driver: directed stimulus pushes per-cycle expectations into a queue;
// an independent monitor compares them against the DUT outputs at the matching cycle.
module tb_hv_driver;

    localparam logic [2:0] S_OFF  = 3'd0;
    localparam logic [2:0] S_DLY  = 3'd1;
    localparam logic [2:0] S_ON   = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_FLT  = 3'd4;

    logic        clk = 1'b0;
    logic        sclr = 1'b1;
    logic        req = 1'b0;
    logic        permit = 1'b0;
    logic [15:0] prescale = 16'd3;
    logic [15:0] on_delay = 16'd2;
    logic [15:0] off_time = 16'd0;
    logic        fault = 1'b0;
    logic        fault_clr = 1'b0;
    logic        hv;
    logic        on_pulse;
    logic        busy;
    logic        locked;
    logic [2:0]  state;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int         cyc;
        logic [6:0] vec;
        string      nm;
    } exp_t;

    exp_t sbq[$];

    hv_driver #(.PRESCALE_WIDTH(16), .WIDTH(16)) dut (
        .clk(clk), .sclr(sclr), .req(req), .permit(permit),
        .prescale(prescale), .on_delay(on_delay), .off_time(off_time),
        .fault(fault), .fault_clr(fault_clr),
        .hv(hv), .on_pulse(on_pulse), .busy(busy), .locked(locked), .state(state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected output vector {state, hv, on_pulse, busy, locked} for a given state
    function automatic logic [6:0] mkvec(logic [2:0] st, logic op);
        return {st, (st == S_ON), op, (st == S_DLY || st == S_HOLD), (st == S_FLT)};
    endfunction

    task automatic expect_at(int c, logic [2:0] st, logic op, string nm);
        exp_t e;
        e.cyc = c;
        e.vec = mkvec(st, op);
        e.nm  = nm;
        sbq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_until(int c);
        while (cyc < c) step();
    endtask

    // Monitor: compare every expectation due in this cycle
    always @(negedge clk) begin
        logic [6:0] act;
        act = {state, hv, on_pulse, busy, locked};
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc <= cyc) begin
                checks++;
                if (sbq[i].cyc < cyc) begin
                    failures++;
                    $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)",
                             sbq[i].nm, sbq[i].cyc, cyc);
                end else if (act !== sbq[i].vec) begin
                    failures++;
                    $display("FAIL %s cyc=%0d actual{st,hv,op,busy,lk}=%0d,%b,%b,%b,%b required=%0d,%b,%b,%b,%b",
                             sbq[i].nm, cyc, act[6:4], act[3], act[2], act[1], act[0],
                             sbq[i].vec[6:4], sbq[i].vec[3], sbq[i].vec[2], sbq[i].vec[1], sbq[i].vec[0]);
                end
                sbq.delete(i);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int t0;

        // Reset
        step();
        expect_at(cyc, S_OFF, 1'b0, "reset");
        expect_at(cyc + 1, S_OFF, 1'b0, "reset_hold");
        step();
        sclr = 1'b0;
        step();
        step();

        // 1: pre-delay of (2+1)*(3+1) cycles
        t0 = cyc;
        prescale = 16'd3; on_delay = 16'd2; req = 1'b1;
        expect_at(t0 + 1,  S_DLY, 1'b0, "t1_ondly");
        expect_at(t0 + 12, S_DLY, 1'b0, "t1_last_dly");
        expect_at(t0 + 13, S_ON,  1'b1, "t1_on");
        expect_at(t0 + 14, S_ON,  1'b0, "t1_pulse_end");
        wait_until(t0 + 20);

        // 2: off-hold of (4+1)*(1+1) cycles, req re-raised during hold
        t0 = cyc;
        prescale = 16'd1; off_time = 16'd4; req = 1'b0;
        expect_at(t0 + 1,  S_HOLD, 1'b0, "t2_hold");
        expect_at(t0 + 10, S_HOLD, 1'b0, "t2_hold_last");
        expect_at(t0 + 11, S_OFF,  1'b0, "t2_off");
        expect_at(t0 + 12, S_DLY,  1'b0, "t2_redly");
        expect_at(t0 + 13, S_OFF,  1'b0, "t2_abort");
        step();
        req = 1'b1;
        wait_until(t0 + 12);
        req = 1'b0;
        wait_until(t0 + 15);

        // 3: req drops during pre-delay -> OFF without hold
        t0 = cyc;
        prescale = 16'd3; on_delay = 16'd5; req = 1'b1;
        expect_at(t0 + 1, S_DLY, 1'b0, "t3_ondly");
        expect_at(t0 + 7, S_DLY, 1'b0, "t3_still_dly");
        expect_at(t0 + 8, S_OFF, 1'b0, "t3_off");
        expect_at(t0 + 9, S_OFF, 1'b0, "t3_no_hold");
        wait_until(t0 + 7);
        req = 1'b0;
        wait_until(t0 + 10);

        // 4: fault in ON, clear ignored while fault high, then discharge hold
        t0 = cyc;
        prescale = 16'd0; off_time = 16'd2; req = 1'b1; permit = 1'b1;
        expect_at(t0 + 1,  S_DLY,  1'b0, "t4_dly");
        expect_at(t0 + 2,  S_ON,   1'b1, "t4_on");
        expect_at(t0 + 3,  S_ON,   1'b0, "t4_on2");
        expect_at(t0 + 5,  S_FLT,  1'b0, "t4_fault");
        expect_at(t0 + 7,  S_FLT,  1'b0, "t4_clr_ignored");
        expect_at(t0 + 9,  S_HOLD, 1'b0, "t4_hold");
        expect_at(t0 + 11, S_HOLD, 1'b0, "t4_hold_last");
        expect_at(t0 + 12, S_OFF,  1'b0, "t4_off");
        wait_until(t0 + 2);
        permit = 1'b0;
        wait_until(t0 + 4);
        fault = 1'b1; req = 1'b0;
        wait_until(t0 + 6);
        fault_clr = 1'b1;
        wait_until(t0 + 8);
        fault = 1'b0;
        wait_until(t0 + 9);
        fault_clr = 1'b0;
        wait_until(t0 + 13);

        // 5: permit bypass, then fault on the ON entry cycle
        t0 = cyc;
        prescale = 16'd3; permit = 1'b1; req = 1'b1;
        expect_at(t0 + 1,  S_DLY,  1'b0, "t5_dly");
        expect_at(t0 + 2,  S_ON,   1'b1, "t5_on");
        expect_at(t0 + 3,  S_HOLD, 1'b0, "t5_hold");
        expect_at(t0 + 4,  S_OFF,  1'b0, "t5_off");
        expect_at(t0 + 8,  S_ON,   1'b1, "t5_on_again");
        expect_at(t0 + 9,  S_FLT,  1'b0, "t5_entry_fault");
        expect_at(t0 + 10, S_HOLD, 1'b0, "t5_flt_hold");
        expect_at(t0 + 11, S_OFF,  1'b0, "t5_flt_off");
        wait_until(t0 + 2);
        req = 1'b0;
        wait_until(t0 + 6);
        req = 1'b1;
        wait_until(t0 + 8);
        fault = 1'b1; req = 1'b0;
        wait_until(t0 + 9);
        fault = 1'b0; fault_clr = 1'b1;
        wait_until(t0 + 10);
        fault_clr = 1'b0;
        wait_until(t0 + 13);

        // 6: sclr mid pre-delay, then on_delay lowered 9 -> 1 at cnt=4
        t0 = cyc;
        permit = 1'b0; prescale = 16'd1; on_delay = 16'd9; req = 1'b1;
        expect_at(t0 + 1,  S_DLY,  1'b0, "t6_dly");
        expect_at(t0 + 4,  S_OFF,  1'b0, "t6_sclr");
        expect_at(t0 + 5,  S_OFF,  1'b0, "t6_sclr_hold");
        expect_at(t0 + 6,  S_DLY,  1'b0, "t6_restart");
        expect_at(t0 + 15, S_DLY,  1'b0, "t6_before_tick");
        expect_at(t0 + 16, S_ON,   1'b1, "t6_lowered_on");
        expect_at(t0 + 17, S_ON,   1'b0, "t6_on2");
        expect_at(t0 + 18, S_HOLD, 1'b0, "t6_hold");
        wait_until(t0 + 3);
        sclr = 1'b1;
        wait_until(t0 + 5);
        sclr = 1'b0;
        wait_until(t0 + 14);
        on_delay = 16'd1;
        wait_until(t0 + 17);
        req = 1'b0;
        wait_until(t0 + 20);

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 50 && sbq.size() > 0; k++) step();
        while (sbq.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL %s: expectation for cycle %0d never checked", sbq[0].nm, sbq[0].cyc);
            void'(sbq.pop_front());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
